// File: rtl/xbus_pkg.sv
// -----------------------------------------------------------------------------
// xbus_pkg
// Shared types and constants for the XBus arbiter and its round-robin picker.
//   XBUS_MAX_MASTERS : physical width of the request/grant vectors
//   xbus_vec_t       : one bit per master (request or grant)
//   xbus_arb_state_e : arbiter phase sequencer states
//   xbus_next_ptr    : round-robin pointer advance with wrap at num_masters-1
// -----------------------------------------------------------------------------
package xbus_pkg;

  localparam int XBUS_MAX_MASTERS = 16;

  typedef logic [XBUS_MAX_MASTERS-1:0] xbus_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } xbus_arb_state_e;

  // Pointer to the master just after idx, wrapping at num_masters-1.
  function automatic logic [3:0] xbus_next_ptr(input logic [3:0] idx,
                                               input int num_masters);
    logic [3:0] last_idx;
    last_idx = 4'(num_masters - 1);
    return (idx == last_idx) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/xbus_rr_picker.sv
// -----------------------------------------------------------------------------
// xbus_rr_picker
// Combinational round-robin selector. Searches upward from ptr for the first
// set request bit, wrapping from NUM_MASTERS-1 back to 0.
//   request    in  16  request vector, already masked to NUM_MASTERS bits
//   ptr        in  4   search start index (always < NUM_MASTERS)
//   winner     out 16  one-hot winner, zero when nothing is requested
//   winner_idx out 4   index of the winner (0 when nothing is requested)
//   found      out 1   at least one request bit was set
// -----------------------------------------------------------------------------
module xbus_rr_picker
  import xbus_pkg::*;
#(
  parameter int NUM_MASTERS = 16
) (
  input  logic [15:0] request,
  input  logic [3:0]  ptr,
  output logic [15:0] winner,
  output logic [3:0]  winner_idx,
  output logic        found
);

  // Candidate index for the current search step; five bits hold ptr+i
  // before the modulo wrap.
  logic [4:0] cand;

  always_comb begin
    winner_idx = '0;
    found      = 1'b0;
    cand       = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = {1'b0, ptr} + 5'(i);
      if (cand >= 5'(NUM_MASTERS)) begin
        cand = cand - 5'(NUM_MASTERS);
      end
      if (!found && request[cand[3:0]]) begin
        found      = 1'b1;
        winner_idx = cand[3:0];
      end
    end
    winner = found ? (16'd1 << winner_idx) : 16'd0;
  end

endmodule

// File: rtl/xbus_arbiter.sv
// -----------------------------------------------------------------------------
// xbus_arbiter
// Central XBus arbiter and phase sequencer. Runs ARB -> ADDR -> DATA, issues a
// one-hot grant for the single address-phase cycle and signals the
// arbitration phase on sig_start. All outputs are registered.
//   sig_clock    in  1   bus clock, rising edge
//   sig_reset_n  in  1   synchronous active-low reset
//   sig_request  in  16  per-master request (bits >= NUM_MASTERS ignored)
//   sig_read     in  1   address-phase read qualifier
//   sig_write    in  1   address-phase write qualifier
//   sig_bip      in  1   burst in progress (data phase)
//   sig_wait     in  1   slave wait (data phase)
//   sig_error    in  1   slave error (data phase)
//   sig_grant    out 16  one-hot grant during the address-phase cycle
//   sig_start    out 1   arbitration phase indicator
//   bus_busy     out 1   high in ADDR or DATA
//   timeout_err  out 1   one-cycle pulse when the wait watchdog aborts
//   rw_conflict  out 1   one-cycle pulse when read and write both set in ADDR
// -----------------------------------------------------------------------------
module xbus_arbiter
  import xbus_pkg::*;
#(
  parameter int NUM_MASTERS  = 16,
  parameter int WAIT_TIMEOUT = 256,
  parameter int CNT_W        = 9
) (
  input  logic        sig_clock,
  input  logic        sig_reset_n,
  input  logic [15:0] sig_request,
  input  logic        sig_read,
  input  logic        sig_write,
  input  logic        sig_bip,
  input  logic        sig_wait,
  input  logic        sig_error,
  output logic [15:0] sig_grant,
  output logic        sig_start,
  output logic        bus_busy,
  output logic        timeout_err,
  output logic        rw_conflict
);

  localparam xbus_vec_t        VALID_MASK = 16'((32'd1 << NUM_MASTERS) - 32'd1);
  localparam logic [CNT_W-1:0] WD_LIMIT   = CNT_W'(WAIT_TIMEOUT);
  localparam bit               WD_EN      = (WAIT_TIMEOUT != 0);

  xbus_arb_state_e state;
  xbus_arb_state_e state_next;

  logic [3:0]       ptr;
  logic [3:0]       ptr_next;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_next;
  logic [CNT_W-1:0] wd_inc;

  xbus_vec_t grant_q;
  xbus_vec_t grant_next;
  logic      start_q;
  logic      start_next;
  logic      busy_q;
  logic      busy_next;
  logic      timeout_q;
  logic      timeout_next;
  logic      rw_q;
  logic      rw_next;

  xbus_vec_t  req_valid;
  xbus_vec_t  pick_onehot;
  logic [3:0] pick_idx;
  logic       pick_found;

  logic xfer_done;
  logic wd_hit;

  assign req_valid = sig_request & VALID_MASK;

  xbus_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .request    (req_valid),
    .ptr        (ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .found      (pick_found)
  );

  // A beat completes when the slave is not waiting and either the burst is
  // over or the slave flagged an error.
  assign xfer_done = !sig_wait && (!sig_bip || sig_error);

  // The watchdog fires on the wait cycle that brings the count to the limit.
  // It only ever coincides with sig_wait=1, so it can never race a normal
  // completion; completion is still given priority below.
  assign wd_inc = wd_cnt + CNT_W'(1);
  assign wd_hit = WD_EN && sig_wait && (wd_inc == WD_LIMIT);

  // State and output registers.
  always_ff @(posedge sig_clock) begin
    if (!sig_reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      wd_cnt    <= '0;
      grant_q   <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      wd_cnt    <= wd_next;
      grant_q   <= grant_next;
      start_q   <= start_next;
      busy_q    <= busy_next;
      timeout_q <= timeout_next;
      rw_q      <= rw_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = ARB;
      ARB:     if (pick_found) state_next = ADDR;
      ADDR:    state_next = (sig_read || sig_write) ? DATA : ARB;
      DATA:    if (xfer_done || wd_hit) state_next = ARB;
      default: state_next = IDLE;
    endcase
  end

  // Registered-output and bookkeeping logic. Start and busy follow directly
  // from the state being entered, which keeps start and grant exclusive.
  always_comb begin
    grant_next   = '0;
    start_next   = (state_next == ARB);
    busy_next    = (state_next == ADDR) || (state_next == DATA);
    timeout_next = (state == DATA) && !xfer_done && wd_hit;
    rw_next      = (state == ADDR) && sig_read && sig_write;
    ptr_next     = ptr;
    wd_next      = wd_cnt;
    case (state)
      ARB: begin
        if (pick_found) begin
          grant_next = pick_onehot;
          ptr_next   = xbus_next_ptr(pick_idx, NUM_MASTERS);
        end
      end
      ADDR: wd_next = '0;
      DATA: wd_next = sig_wait ? wd_inc : '0;
      default: ;
    endcase
  end

  assign sig_grant   = grant_q;
  assign sig_start   = start_q;
  assign bus_busy    = busy_q;
  assign timeout_err = timeout_q;
  assign rw_conflict = rw_q;

endmodule

// File: doc/xbus_arbiter.md
Name: xbus_arbiter

Overview:
- Central bus arbiter and phase sequencer for the XBus. Shares the bus among up to 16 masters.
- Samples sig_request, issues a one-hot sig_grant for exactly the address-phase cycle, and drives sig_start during the arbitration phase.
- Tracks the data phase via sig_read/sig_write/sig_wait/sig_bip/sig_error to decide when the next arbitration may begin.
- Sits beside the bus interface as the only driver of sig_grant and sig_start.

Parameters:
- NUM_MASTERS, 16, number of active request/grant lines (1..16); request bits at or above NUM_MASTERS are ignored, the matching grant bits are tied 0.
- WAIT_TIMEOUT, 256, maximum consecutive data-phase cycles with sig_wait=1 before the transfer is aborted; 0 disables the watchdog.
- CNT_W, 9, width of the wait watchdog counter; must satisfy 2**CNT_W > WAIT_TIMEOUT.

Ports:
- sig_clock  in  1  bus clock; all logic rising-edge.
- sig_reset_n  in  1  synchronous, active-low reset.
- sig_request  in  16  per-master bus request.
- sig_read  in  1  address-phase read qualifier.
- sig_write  in  1  address-phase write qualifier.
- sig_bip  in  1  burst-in-progress from the active master.
- sig_wait  in  1  slave wait, data phase.
- sig_error  in  1  slave error, data phase.
- sig_grant  out  16  one-hot grant, asserted only during the address-phase cycle.
- sig_start  out  1  arbitration-phase indicator.
- bus_busy  out  1  high in ADDR or DATA.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- rw_conflict  out  1  one-cycle pulse when read and write are both 1 in ADDR.

Behaviour:
- All outputs are registered.
- While sig_reset_n=0, sampled at the edge: state=IDLE, sig_grant=0, sig_start=0, bus_busy=0, timeout_err=0, rw_conflict=0, rr pointer=0, watchdog=0.
- Reset asserted mid-transfer aborts immediately, with no completion of the data phase.
- States: IDLE, ARB, ADDR, DATA.
- IDLE: start=0. Next edge goes to ARB with start<=1.
- ARB: start=1, grant=0.
  - If any valid request bit is set at the edge: grant<=onehot(winner), start<=0, go to ADDR.
  - Otherwise stay in ARB with start held at 1.
  - Request-to-grant latency is 1 clock from the edge at which the request is sampled.
- Winner selection is round-robin: first set bit searching upward from ptr, wrapping at NUM_MASTERS-1 to 0.
  - ptr<=winner+1 (mod NUM_MASTERS) on every grant.
  - Masters that do not request are skipped without consuming a turn.
- ADDR: exactly one cycle; grant one-hot.
  - Next edge: grant<=0.
  - If sig_read|sig_write, go to DATA and clear the watchdog.
  - Otherwise (NOP), go to ARB with start<=1.
  - If sig_read&sig_write: rw_conflict pulses and the transfer still proceeds to DATA.
- DATA: grant=0, start=0, bus_busy=1.
  - At each edge, if sig_wait=0 and (sig_bip=0 or sig_error=1): transfer ends, go to ARB with start<=1.
  - sig_wait=1: watchdog increments; it is cleared on any sig_wait=0 cycle.
  - When the watchdog reaches WAIT_TIMEOUT (and WAIT_TIMEOUT≠0): timeout_err pulses, go to ARB with start<=1.
- The minimum transfer is ARB, ADDR, DATA(1), so the bus is re-arbitrated every 3 cycles at best; a NOP takes 2 cycles.
- A requester that drops its request between ARB and ADDR still receives the grant; the master is responsible for a NOP.
- Simultaneous end-of-transfer and watchdog hit: normal completion wins and timeout_err is not pulsed.
- Invariant: sig_grant is $onehot0 in every cycle; sig_start and a nonzero grant are never high together.

Decomposition:
- Shared package xbus_pkg holds:
  - enum xbus_arb_state_e {IDLE, ARB, ADDR, DATA}
  - constant XBUS_MAX_MASTERS=16
  - a typedef for the 16-bit request/grant vector
- One combinational sub-module, xbus_rr_picker: inputs are the masked request vector and ptr; outputs are a one-hot winner and its index. It is reusable and unit-testable alone.

Test Plan:
- Reset release with request=0 → start=0 in the reset cycle; start=1 one cycle later; grant stays 0 indefinitely.
- request=16'h0001, write=1, wait=0, bip=0 → grant=16'h0001 for exactly 1 cycle, then DATA for 1 cycle, then start=1; the sequence repeats every 3 cycles.
- request=16'h8005 held, each transfer single-beat → grant order 0x0001, 0x0004, 0x8000, 0x0001 (round-robin with wrap).
- Granted master drives read=write=0 (NOP) → start returns 1 cycle after grant, bus_busy is low in the NOP return cycle, and no DATA state is entered.
- Write burst with bip=1 for 3 beats, wait=1 for 2 cycles on beat 2 → DATA lasts 5 cycles; start rises after the beat where bip=0 and wait=0. Separately, wait held at 1 with WAIT_TIMEOUT=4 → timeout_err pulses once after 4 wait cycles and start=1 on the next cycle.
- sig_reset_n driven low mid-DATA → grant=0, start=0, state=IDLE at the next edge; ptr=0, so the next arbitration favours master 0.
